// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: scalar LSU on port 0, SIMD LSU on port 1.
// Grants are held through downstream stalls; read responses are routed back via an in-order ID FIFO.
module dmem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          FIXED_PRIO      = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic [3:0]  m0_req_wmask,
    input  logic        m0_req_write,
    output logic        m0_resp_valid,
    input  logic        m0_resp_ready,
    output logic [31:0] m0_resp_rdata,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic [3:0]  m1_req_wmask,
    input  logic        m1_req_write,
    output logic        m1_resp_valid,
    input  logic        m1_resp_ready,
    output logic [31:0] m1_resp_rdata,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    output logic        mem_req_write,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_rdata,

    output logic        err_spurious_resp
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] DEPTH    = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        LOCK_NONE,
        LOCK_P0,
        LOCK_P1
    } lock_t;

    lock_t         lock_q;
    lock_t         lock_d;
    logic          last_grant;
    logic          id_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          err_q;

    logic full;
    logic empty;
    logic elig0;
    logic elig1;
    logic grant;
    logic accept;
    logic push;
    logic pop;
    logic head;
    logic resp_live;
    logic spurious;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == DEPTH);
    assign empty = (count == '0);

    // A full ID FIFO only blocks loads; stores never produce a response.
    assign elig0 = m0_req_valid & (m0_req_write | ~full);
    assign elig1 = m1_req_valid & (m1_req_write | ~full);

    always_comb begin
        grant = 1'b0;
        case (lock_q)
            LOCK_P0: grant = 1'b0;
            LOCK_P1: grant = 1'b1;
            default: begin
                if (elig0 && elig1) begin
                    grant = FIXED_PRIO ? 1'b0 : ~last_grant;
                end else begin
                    grant = elig1;
                end
            end
        endcase
    end

    assign mem_req_valid = resetn & (grant ? elig1 : elig0);
    assign mem_req_addr  = grant ? m1_req_addr  : m0_req_addr;
    assign mem_req_wdata = grant ? m1_req_wdata : m0_req_wdata;
    assign mem_req_wmask = grant ? m1_req_wmask : m0_req_wmask;
    assign mem_req_write = grant ? m1_req_write : m0_req_write;

    assign m0_req_ready = resetn & ~grant & mem_req_ready & elig0;
    assign m1_req_ready = resetn &  grant & mem_req_ready & elig1;

    assign accept = mem_req_valid & mem_req_ready;
    assign push   = accept & ~mem_req_write;

    assign head          = id_mem[rd_ptr];
    assign resp_live     = resetn & mem_resp_valid & ~empty;
    assign m0_resp_valid = resp_live & ~head;
    assign m1_resp_valid = resp_live &  head;
    assign m0_resp_rdata = mem_resp_rdata;
    assign m1_resp_rdata = mem_resp_rdata;

    // With nothing outstanding the response is sunk so it cannot wedge the memory.
    assign mem_resp_ready = resetn & (empty | (head ? m1_resp_ready : m0_resp_ready));
    assign pop            = mem_resp_valid & mem_resp_ready & ~empty;
    assign spurious       = mem_resp_valid & mem_resp_ready & empty;

    always_comb begin
        lock_d = LOCK_NONE;
        if (mem_req_valid && !mem_req_ready) begin
            lock_d = grant ? LOCK_P1 : LOCK_P0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q     <= LOCK_NONE;
            last_grant <= 1'b1;
        end else begin
            lock_q <= lock_d;
            if (accept) begin
                last_grant <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                id_mem[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= grant;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (spurious) begin
            err_q <= 1'b1;
        end
    end

    assign err_spurious_resp = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin and fixed-priority instances share stimulus;
// expected read responses are queued at request time and popped when the DUT routes them.
module tb_dmem_arbiter;

    logic        clk;
    logic        resetn;

    logic        m0_req_valid, m0_req_write, m0_resp_ready;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic [3:0]  m0_req_wmask;
    logic        m1_req_valid, m1_req_write, m1_resp_ready;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_wmask;
    logic        mem_req_ready, mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    logic        m0_req_ready, m0_resp_valid, m1_req_ready, m1_resp_valid;
    logic [31:0] m0_resp_rdata, m1_resp_rdata;
    logic        mem_req_valid, mem_req_write, mem_resp_ready, err_spurious_resp;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;

    logic        fp_m0_req_ready, fp_m0_resp_valid, fp_m1_req_ready, fp_m1_resp_valid;
    logic [31:0] fp_m0_resp_rdata, fp_m1_resp_rdata;
    logic        fp_mem_req_valid, fp_mem_req_write, fp_mem_resp_ready, fp_err;
    logic [31:0] fp_mem_req_addr, fp_mem_req_wdata;
    logic [3:0]  fp_mem_req_wmask;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    dmem_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask), .m0_req_write(m0_req_write),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(m0_resp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask), .m1_req_write(m1_req_write),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(m1_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_write(mem_req_write),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
        .err_spurious_resp(err_spurious_resp)
    );

    dmem_arbiter #(.MAX_OUTSTANDING(2), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_req_valid(m0_req_valid), .m0_req_ready(fp_m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask), .m0_req_write(m0_req_write),
        .m0_resp_valid(fp_m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(fp_m0_resp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(fp_m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask), .m1_req_write(m1_req_write),
        .m1_resp_valid(fp_m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(fp_m1_resp_rdata),
        .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(fp_mem_req_addr),
        .mem_req_wdata(fp_mem_req_wdata), .mem_req_wmask(fp_mem_req_wmask), .mem_req_write(fp_mem_req_write),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(fp_mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
        .err_spurious_resp(fp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic w, input logic [31:0] a);
        m0_req_valid = v;
        m0_req_write = w;
        m0_req_addr  = a;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [31:0] a);
        m1_req_valid = v;
        m1_req_write = w;
        m1_req_addr  = a;
    endtask

    // Memory model: returns the data queued for the oldest accepted load.
    task automatic drive_resp();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = (exp_q.size() != 0) ? exp_q[0].data : 32'h0;
    endtask

    task automatic resp_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            assert (0) else begin
                miscompares++;
                $error("FAIL %s: observed response with empty scoreboard, expected queued entry", tag);
            end
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_owner_valid"}, e.port ? m1_resp_valid : m0_resp_valid, 32'd1);
            chk({tag, "_other_valid"}, e.port ? m0_resp_valid : m1_resp_valid, 32'd0);
            chk({tag, "_rdata"}, e.port ? m1_resp_rdata : m0_resp_rdata, e.data);
            chk({tag, "_mem_ready"}, mem_resp_ready, 32'd1);
        end
    endtask

    initial begin
        resetn = 1'b0;
        drive0(1'b1, 1'b0, 32'h10);
        drive1(1'b1, 1'b0, 32'h20);
        m0_req_wdata = 32'h0; m0_req_wmask = 4'h0;
        m1_req_wdata = 32'h0; m1_req_wmask = 4'h0;
        m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0;
        cyc();
        chk("rst_m0_req_ready", m0_req_ready, 0);
        chk("rst_m1_req_ready", m1_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_m0_resp_valid", m0_resp_valid, 0);
        chk("rst_m1_resp_valid", m1_resp_valid, 0);
        chk("rst_mem_resp_ready", mem_resp_ready, 0);
        chk("rst_err", err_spurious_resp, 0);
        cyc();
        resetn = 1'b1;
        mem_resp_valid = 1'b0;

        // Both ports load back to back; responses overlap with new pushes.
        for (int k = 0; k < 5; k++) begin
            logic g;
            g = logic'(k % 2);
            if (k >= 1) drive_resp(); else mem_resp_valid = 1'b0;
            #1;
            chk("rr_m0_ready", m0_req_ready, g ? 0 : 1);
            chk("rr_m1_ready", m1_req_ready, g ? 1 : 0);
            chk("rr_addr", mem_req_addr, g ? 32'h20 : 32'h10);
            chk("fp_m0_ready", fp_m0_req_ready, 1);
            chk("fp_m1_ready", fp_m1_req_ready, 0);
            if (k >= 1) resp_check("rr_resp");
            exp_q.push_back('{port: g, data: 32'hC0DE_0000 + 32'(k)});
            cyc();
        end
        drive0(1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0);
        drive_resp();
        #1;
        resp_check("rr_drain");
        cyc();
        mem_resp_valid = 1'b0;

        // Stalled grant on port 0 must not move when port 1 appears.
        mem_req_ready = 1'b0;
        drive0(1'b1, 1'b0, 32'h100);
        #1;
        chk("stall_valid", mem_req_valid, 1);
        chk("stall_addr0", mem_req_addr, 32'h100);
        chk("stall_m0_ready", m0_req_ready, 0);
        cyc();
        drive1(1'b1, 1'b0, 32'h200);
        for (int s = 0; s < 2; s++) begin
            #1;
            chk("lock_addr", mem_req_addr, 32'h100);
            chk("lock_m1_ready", m1_req_ready, 0);
            cyc();
        end
        mem_req_ready = 1'b1;
        #1;
        chk("lock_accept_m0", m0_req_ready, 1);
        chk("lock_accept_m1", m1_req_ready, 0);
        exp_q.push_back('{port: 1'b0, data: 32'h0000_AAAA});
        cyc();
        drive0(1'b0, 1'b0, 32'h0);
        #1;
        chk("after_lock_m1", m1_req_ready, 1);
        chk("after_lock_addr", mem_req_addr, 32'h200);
        exp_q.push_back('{port: 1'b1, data: 32'h0000_BBBB});
        cyc();

        // FIFO full: load blocked, store from port 1 still goes through.
        drive0(1'b1, 1'b0, 32'h300);
        drive1(1'b1, 1'b1, 32'h400);
        m1_req_wmask = 4'b0011;
        m1_req_wdata = 32'h5678_5678;
        #1;
        chk("full_m0_blocked", m0_req_ready, 0);
        chk("full_store_m1", m1_req_ready, 1);
        chk("full_store_write", mem_req_write, 1);
        chk("full_store_wmask", mem_req_wmask, 4'b0011);
        chk("full_store_wdata", mem_req_wdata, 32'h5678_5678);
        chk("full_store_addr", mem_req_addr, 32'h400);
        cyc();
        drive1(1'b0, 1'b0, 32'h0);
        m1_req_wmask = 4'h0;
        drive_resp();
        #1;
        chk("full_still_blocked", m0_req_ready, 0);
        chk("full_mem_valid", mem_req_valid, 0);
        resp_check("resp_aaaa");
        cyc();
        m1_resp_ready = 1'b0;
        drive_resp();
        #1;
        chk("post_pop_load", m0_req_ready, 1);
        chk("post_pop_addr", mem_req_addr, 32'h300);
        exp_q.push_back('{port: 1'b0, data: 32'h0000_CCCC});
        for (int s = 0; s < 2; s++) begin
            if (s == 1) begin
                drive0(1'b0, 1'b0, 32'h0);
                #1;
            end
            chk("bp_m1_valid", m1_resp_valid, 1);
            chk("bp_m0_valid", m0_resp_valid, 0);
            chk("bp_mem_ready", mem_resp_ready, 0);
            cyc();
        end
        m1_resp_ready = 1'b1;
        #1;
        resp_check("resp_bbbb");
        cyc();
        drive_resp();
        #1;
        resp_check("resp_cccc");
        cyc();

        // Response with nothing outstanding.
        mem_resp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("spur_mem_ready", mem_resp_ready, 1);
        chk("spur_m0_valid", m0_resp_valid, 0);
        chk("spur_m1_valid", m1_resp_valid, 0);
        chk("spur_err_before", err_spurious_resp, 0);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        chk("spur_err_set", err_spurious_resp, 1);
        cyc();
        cyc();
        chk("spur_err_sticky", err_spurious_resp, 1);

        // Reset in the middle of a stalled request with a read outstanding.
        drive0(1'b1, 1'b0, 32'h500);
        #1;
        chk("mid_accept", m0_req_ready, 1);
        cyc();
        drive0(1'b0, 1'b0, 32'h500);
        drive1(1'b1, 1'b0, 32'h600);
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_5555;
        #1;
        chk("mid_pre_resp", m0_resp_valid, 1);
        chk("mid_pre_reqv", mem_req_valid, 1);
        resetn = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("mid_rst_reqv", mem_req_valid, 0);
        chk("mid_rst_m1_ready", m1_req_ready, 0);
        chk("mid_rst_respv", m0_resp_valid, 0);
        chk("mid_rst_mem_ready", mem_resp_ready, 0);
        chk("mid_rst_err", err_spurious_resp, 0);
        cyc();
        resetn = 1'b1;
        drive0(1'b1, 1'b0, 32'h500);
        mem_req_ready = 1'b0;
        #1;
        chk("post_rst_tie_addr", mem_req_addr, 32'h500);
        chk("post_rst_respv", m0_resp_valid, 0);
        chk("post_rst_mem_ready", mem_resp_ready, 1);
        chk("post_rst_err", err_spurious_resp, 0);
        cyc();
        chk("post_rst_spur_err", err_spurious_resp, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
